// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder.
// State encoding, mailbox default and counter width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int CYC_W = 16;

  localparam logic [7:0] DONE_ADR_DEF = 8'hFF;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

endpackage

// File: rtl/mips_mem_responder_bytemem.sv
// Byte RAM: one synchronous write port, one asynchronous read port.
// No reset; contents survive responder resets.
module bytemem #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  // write port commits on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: boot loader, zero-wait RAM, mailbox.
// Holds the core in reset until the load stream completes.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH_BITS = 8,
  parameter logic [WIDTH-1:0] DONE_ADR   = WIDTH'(DONE_ADR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [WIDTH-1:0]  adr,
  input  logic [WIDTH-1:0]  writedata,
  output logic [WIDTH-1:0]  memdata,
  output logic              core_reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [CYC_W-1:0]  cycles
);

  localparam logic [DEPTH_BITS-1:0] LAST_ADR = '1;

  state_e                state_q, state_d;
  logic [DEPTH_BITS-1:0] load_adr_q, load_adr_d;
  logic [CYC_W-1:0]      cycles_q, cycles_d;
  logic [WIDTH-1:0]      result_q, result_d;

  logic                  we;
  logic [DEPTH_BITS-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;

  bytemem #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (adr[DEPTH_BITS-1:0]),
    .rdata (rdata)
  );

  // next state, write-port mux, counters and mailbox latch
  always_comb begin
    state_d    = state_q;
    load_adr_d = load_adr_q;
    cycles_d   = cycles_q;
    result_d   = result_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    unique case (state_q)
      IDLE: begin
        state_d    = LOAD;
        load_adr_d = '0;
      end
      LOAD: begin
        if (load_valid) begin
          we         = 1'b1;
          waddr      = load_adr_q;
          wdata      = WIDTH'(load_data);
          load_adr_d = load_adr_q + 1'b1;
          if (load_last || load_adr_q == LAST_ADR) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + 1'b1;
        end
        if (memwrite) begin
          we    = 1'b1;
          waddr = adr[DEPTH_BITS-1:0];
          wdata = writedata;
          if (adr == DONE_ADR) begin
            result_d = writedata;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      load_adr_q <= '0;
      cycles_q   <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_adr_q <= load_adr_d;
      cycles_q   <= cycles_d;
      result_q   <= result_d;
    end
  end

  assign core_reset = (state_q != RUN);
  assign load_ready = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign memdata    = (state_q == RUN && memread) ? rdata : '0;
  assign result     = result_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder.
// Reference model plus literal anchors.
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [7:0]  adr = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  memdata;
  logic        core_reset;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        done;
  logic [7:0]  result;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .adr        (adr),
    .writedata  (writedata),
    .memdata    (memdata),
    .core_reset (core_reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .done       (done),
    .result     (result),
    .cycles     (cycles)
  );

  // reference model: what the responder must be doing
  logic [7:0] m_mem [256];
  bit         m_known [256];
  bit         m_started = 0;
  bit         m_loading = 0;
  bit         m_running = 0;
  bit         m_finished = 0;
  int         m_cyc = 0;
  logic [7:0] m_res = '0;
  int         m_ladr = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_started  = 0;
      m_loading  = 0;
      m_running  = 0;
      m_finished = 0;
      m_cyc      = 0;
      m_res      = '0;
      m_ladr     = 0;
    end else if (!m_started) begin
      m_started = 1;
      m_loading = 1;
      m_ladr    = 0;
    end else if (m_loading) begin
      if (load_valid) begin
        m_mem[m_ladr]   = load_data;
        m_known[m_ladr] = 1;
        if (load_last || m_ladr == 255) begin
          m_loading = 0;
          m_running = 1;
        end
        m_ladr = (m_ladr + 1) % 256;
      end
    end else if (m_running) begin
      if (m_cyc < 65535) m_cyc++;
      if (memwrite) begin
        m_mem[int'(adr)]   = writedata;
        m_known[int'(adr)] = 1;
        if (adr == 8'hFF) begin
          m_running  = 0;
          m_finished = 1;
          m_res      = writedata;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("core_reset", core_reset, !m_running);
    chk("load_ready", load_ready, m_loading);
    chk("done", done, m_finished);
    chk("result", result, m_res);
    chk("cycles", cycles, m_cyc);
    if (!(m_running && memread)) begin
      chk("memdata_off", memdata, 0);
    end else if (m_known[int'(adr)]) begin
      chk("memdata", memdata, m_mem[int'(adr)]);
    end
  end

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    memread  = 1'b1;
    memwrite = 1'b0;
    adr      = a;
    @(negedge clk);
    chk("rd_lit", memdata, exp);
    @(posedge clk);
    #1;
    memread = 1'b0;
  endtask

  task automatic do_reset();
    memread    = 1'b0;
    memwrite   = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    #2;
    reset   = 1'b0;
    memread = 1'b1;
    #1;
    chk("rst_memdata", memdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cycles", cycles, 0);
    memread = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("load_ready_edge1", load_ready, 1);
    chk("core_reset_edge1", core_reset, 1);
  endtask

  logic [7:0] q[$];

  task automatic load_q(input bit use_last, input bit gaps);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < q.size() && guard < 4000) begin
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = load_valid ? q[sent] : 8'($urandom);
      load_last  = use_last && (sent == q.size() - 1);
      if (!load_valid) load_last = 1'($urandom);
      memread  = 1'($urandom);
      adr      = 8'($urandom);
      step();
      if (load_valid) sent++;
      guard++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    memread    = 1'b0;
    checks++;
    if (guard >= 4000) begin
      errors++;
      $display("FAIL load_timeout: sent %0d of %0d", sent, q.size());
    end
  endtask

  initial begin
    int k;
    // phase A: short load, reads, writes, mailbox
    do_reset();
    q = '{8'h80, 8'h02, 8'h00, 8'h05};
    load_q(1, 0);
    chk("core_reset_after_load", core_reset, 0);
    chk("load_ready_after_load", load_ready, 0);
    k = 0;
    rd(8'd0, 8'h80); k++;
    rd(8'd1, 8'h02); k++;
    rd(8'd2, 8'h00); k++;
    rd(8'd3, 8'h05); k++;
    adr = 8'd3;
    @(negedge clk);
    chk("memread_low", memdata, 0);
    @(posedge clk); #1; k++;
    memwrite = 1'b1; adr = 8'h10; writedata = 8'h5A;
    step(); k++;
    memwrite = 1'b0;
    rd(8'h10, 8'h5A); k++;
    memread = 1'b1; memwrite = 1'b1; adr = 8'h10; writedata = 8'hA5;
    @(negedge clk);
    chk("rw_same_cycle", memdata, 8'h5A);
    @(posedge clk); #1; k++;
    memwrite = 1'b0; memread = 1'b0;
    rd(8'h10, 8'hA5); k++;
    repeat (3) begin step(); k++; end
    memwrite = 1'b1; adr = 8'hFF; writedata = 8'h07;
    step();
    memwrite = 1'b0;
    chk("mbox_done", done, 1);
    chk("mbox_result", result, 8'h07);
    chk("mbox_core_reset", core_reset, 1);
    chk("mbox_cycles", cycles, k + 1);
    memread = 1'b1; adr = 8'd3;
    @(negedge clk);
    chk("done_memdata", memdata, 0);
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b1; writedata = 8'hEE;
    step();
    memwrite = 1'b0;
    chk("done_result_hold", result, 8'h07);
    // phase A2: RAM retained, DONE write ignored
    do_reset();
    q = '{8'h11, 8'h22};
    load_q(1, 0);
    rd(8'd3, 8'h05);
    rd(8'd0, 8'h11);
    rd(8'h10, 8'hA5);
    // phase B: full load with gaps, auto exit
    do_reset();
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    load_q(0, 1);
    chk("auto_exit", core_reset, 0);
    for (int i = 0; i < 256; i++) begin
      memread = 1'b1; adr = 8'(i);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      adr = 8'($urandom);
      if (adr == 8'hFF) adr = 8'hFE;
      memread   = 1'($urandom);
      memwrite  = 1'($urandom);
      writedata = 8'($urandom);
      step();
    end
    memread = 1'b0; memwrite = 1'b0;
    // phase C: saturate cycles, then reset mid-run
    repeat (65600) step();
    chk("cycles_sat", cycles, 16'hFFFF);
    do_reset();
    q = '{8'h33, 8'h44};
    load_q(1, 0);
    rd(8'd0, 8'h33);
    for (int i = 0; i < 256; i++) begin
      memread = 1'b1; adr = 8'(i);
      step();
    end
    memread = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
